// File: rtl/salu_issue.sv
// salu_issue: issue stage in front of a registered scalar ALU with a
// 2-entry result buffer and a valid/ready writeback port.
// The ALU sits outside this block. Operands go out combinationally, and
// the ALU's result comes back one cycle later. It is matched to the
// in-flight tag, then queued for writeback.
// Optional feature: define SALU_ISSUE_PERF_EN to compile in the issue and
// taken-branch performance counters. Without it, both counter ports read 0.

module salu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_op_i,
    input  logic [DATA_WIDTH-1:0] req_rs1_i,
    input  logic [DATA_WIDTH-1:0] req_rs2_i,
    input  logic [4:0]            req_rd_i,
    output logic [DATA_WIDTH-1:0] alu_rs1_o,
    output logic [DATA_WIDTH-1:0] alu_rs2_o,
    output logic [3:0]            alu_op_o,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic                  alu_zero_i,
    input  logic                  alu_ovf_i,
    input  logic                  flush_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            wb_rd_o,
    output logic                  wb_we_o,
    output logic                  wb_is_br_o,
    output logic                  wb_br_taken_o,
    output logic                  wb_ovf_o,
    output logic [31:0]           perf_issued_o,
    output logic [31:0]           perf_taken_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_BLTU = 4'd14;
    localparam logic [3:0] OP_BGEU = 4'd15;

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    // In-flight tag: describes the operation whose ALU result arrives next cycle
    logic                  tag_valid_q, tag_valid_d;
    logic [3:0]            tag_op_q, tag_op_d;
    logic [4:0]            tag_rd_q, tag_rd_d;

    // Result buffer state
    logic [1:0]            occ_q, occ_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_d [DEPTH];
    logic [3:0]            buf_op_q   [DEPTH];
    logic [3:0]            buf_op_d   [DEPTH];
    logic [4:0]            buf_rd_q   [DEPTH];
    logic [4:0]            buf_rd_d   [DEPTH];
    logic                  buf_zero_q [DEPTH];
    logic                  buf_zero_d [DEPTH];
    logic                  buf_ovf_q  [DEPTH];
    logic                  buf_ovf_d  [DEPTH];

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [2:0]            occ_after;

    logic [DATA_WIDTH-1:0] head_data;
    logic [3:0]            head_op;
    logic [4:0]            head_rd;
    logic                  head_zero;
    logic                  head_ovf;

    assign alu_rs1_o = req_rs1_i;
    assign alu_rs2_o = req_rs2_i;
    assign alu_op_o  = req_op_i;

    assign wb_valid_o = (occ_q != 2'd0);
    assign pop        = wb_valid_o & wb_ready_i;
    assign push       = tag_valid_q & ~flush_i;

    assign head_data  = buf_data_q[rd_ptr_q];
    assign head_op    = buf_op_q[rd_ptr_q];
    assign head_rd    = buf_rd_q[rd_ptr_q];
    assign head_zero  = buf_zero_q[rd_ptr_q];
    assign head_ovf   = buf_ovf_q[rd_ptr_q];

    // Accept only if the buffer can still hold the result after this cycle's pop
    always_comb begin
        occ_after   = {1'b0, occ_q} + {2'b00, tag_valid_q} - {2'b00, pop};
        req_ready_o = ~flush_i & (occ_after < DEPTH_L);
        issue       = req_valid_i & req_ready_o;
    end

    // Next-state for the in-flight tag
    always_comb begin
        tag_valid_d = issue;
        tag_op_d    = tag_op_q;
        tag_rd_d    = tag_rd_q;
        if (issue) begin
            tag_op_d = req_op_i;
            tag_rd_d = req_rd_i;
        end
    end

    // Next-state for occupancy and pointers; a flush empties the buffer after any pop
    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Write the returning ALU result into the tail entry
    always_comb begin
        buf_data_d = buf_data_q;
        buf_op_d   = buf_op_q;
        buf_rd_d   = buf_rd_q;
        buf_zero_d = buf_zero_q;
        buf_ovf_d  = buf_ovf_q;
        if (push) begin
            buf_data_d[wr_ptr_q] = alu_res_i;
            buf_op_d[wr_ptr_q]   = tag_op_q;
            buf_rd_d[wr_ptr_q]   = tag_rd_q;
            buf_zero_d[wr_ptr_q] = alu_zero_i;
            buf_ovf_d[wr_ptr_q]  = alu_ovf_i;
        end
    end

    // Decode the head entry into writeback attributes; all zero while empty
    always_comb begin
        wb_data_o     = '0;
        wb_rd_o       = 5'd0;
        wb_is_br_o    = 1'b0;
        wb_br_taken_o = 1'b0;
        wb_ovf_o      = 1'b0;
        wb_we_o       = 1'b0;
        if (wb_valid_o) begin
            wb_data_o  = head_data;
            wb_rd_o    = head_rd;
            wb_is_br_o = (head_op >= OP_BEQ);
            wb_we_o    = ~wb_is_br_o & (head_rd != 5'd0);
            wb_ovf_o   = ((head_op == OP_ADD) | (head_op == OP_SUB)) & head_ovf;
            case (head_op)
                OP_BEQ:           wb_br_taken_o = head_zero;
                OP_BNE:           wb_br_taken_o = ~head_zero;
                OP_BLT, OP_BLTU:  wb_br_taken_o = head_data[0];
                OP_BGE, OP_BGEU:  wb_br_taken_o = ~head_data[0];
                default:          wb_br_taken_o = 1'b0;
            endcase
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Payload registers need no reset; they are only observed behind valid bits
    always_ff @(posedge clk) begin
        tag_op_q   <= tag_op_d;
        tag_rd_q   <= tag_rd_d;
        buf_data_q <= buf_data_d;
        buf_op_q   <= buf_op_d;
        buf_rd_q   <= buf_rd_d;
        buf_zero_q <= buf_zero_d;
        buf_ovf_q  <= buf_ovf_d;
    end

`ifdef SALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_taken_q, perf_taken_d;

    // Free-running counters of issues and of taken branches leaving the buffer
    always_comb begin
        perf_issued_d = perf_issued_q + {31'd0, issue};
        perf_taken_d  = perf_taken_q + {31'd0, pop & wb_br_taken_o};
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= 32'd0;
            perf_taken_q  <= 32'd0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_taken_q  <= perf_taken_d;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_taken_o  = perf_taken_q;
`else
    assign perf_issued_o = 32'd0;
    assign perf_taken_o  = 32'd0;
`endif

endmodule

// File: doc/salu_issue.md
SALU_ISSUE -- requirements
Module: salu_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand/result width.
REQ-002 SHALL have parameter DEPTH, fixed at 2, giving the number of result buffer entries.
REQ-003 SHALL have port clk  in  1  as its single clock; every flop samples on the rising edge.
REQ-004 SHALL have port rst  in  1  as a synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  in  1  marking the issue request as valid.
REQ-006 SHALL have port req_ready_o  out  1  marking the block as able to accept an issue request.
REQ-007 SHALL have port req_op_i  in  4  carrying the ALU opcode (ADD=0 ... BGEU=15, per the scalar ALU encoding).
REQ-008 SHALL have ports req_rs1_i, req_rs2_i  in  DATA_WIDTH  carrying the operands.
REQ-009 SHALL have port req_rd_i  in  5  carrying the destination register.
REQ-010 SHALL have ports alu_rs1_o, alu_rs2_o  out  DATA_WIDTH  and alu_op_o  out  4  as the ALU inputs.
REQ-011 SHALL have ports alu_res_i  in  DATA_WIDTH  and alu_zero_i, alu_ovf_i  in  1  as the registered ALU outputs.
REQ-012 SHALL have port flush_i  in  1  to kill all in-flight and buffered operations.
REQ-013 SHALL have port wb_valid_o  out  1  and port wb_ready_i  in  1  as the writeback handshake.
REQ-014 SHALL have ports wb_data_o  out  DATA_WIDTH  and wb_rd_o  out  5  carrying the result and its destination.
REQ-015 SHALL have ports wb_we_o, wb_is_br_o, wb_br_taken_o, wb_ovf_o  out  1  carrying the result attributes.
REQ-016 SHALL have ports perf_issued_o, perf_taken_o  out  32  carrying the performance counters.

Function
REQ-017 SHALL define issue as req_valid_i & req_ready_o.
REQ-018 SHALL define pop as wb_valid_o & wb_ready_i.
REQ-019 SHALL drive alu_rs1_o, alu_rs2_o and alu_op_o combinationally from req_rs1_i, req_rs2_i and req_op_i, irrespective of issue.
REQ-020 SHALL, on issue, set the in-flight tag (valid, op, rd) at the next edge; clear the tag valid bit otherwise.
REQ-021 SHALL, when the tag is valid, capture alu_res_i, alu_zero_i and alu_ovf_i into the buffer tail in that cycle, exactly 1 cycle after issue.
REQ-022 SHALL drive req_ready_o = !flush_i & ((occ + tag_valid - pop) < DEPTH); this is a combinational path from wb_ready_i, and the result buffer can never overflow.
REQ-023 SHALL make the buffer a FIFO with 2 entries, a 2-bit occupancy count, 1-bit wrapping pointers, and simultaneous push and pop allowed (occupancy unchanged).
REQ-024 SHALL drive wb_valid_o = (occ != 0) and present the head entry; the head SHALL stay stable while wb_valid_o & !wb_ready_i.
REQ-025 SHALL set wb_is_br_o = 1 for opcodes 10 to 15.
REQ-026 SHALL set wb_we_o = !wb_is_br_o & (rd != 0).
REQ-027 SHALL compute wb_br_taken_o as: BEQ zero; BNE !zero; BLT/BLTU res[0]; BGE/BGEU !res[0]; 0 for non-branch.
REQ-028 SHALL set wb_ovf_o = captured alu_ovf_i for ADD/SUB, else 0.
REQ-029 SHALL, when flush_i is high, clear the tag, occupancy and pointers at the next edge; the ALU result that arrives for a flushed tag SHALL be discarded.
REQ-030 SHALL, when flush_i coincides with a pop, still complete that pop and then empty the buffer.
REQ-031 SHALL provide full throughput: with wb_ready_i held at 1, one issue per cycle is sustained with no bubbles.

Reset
REQ-032 SHALL, while rst is high at an edge, clear the tag valid bit, occupancy and pointers, and zero perf_issued_o and perf_taken_o.
REQ-033 SHALL, in the cycle after reset, output wb_valid_o=0 and req_ready_o=!flush_i; wb_data_o, wb_rd_o and the attribute outputs SHALL read 0.
REQ-034 SHALL give rst priority over flush_i, issue and pop in the same cycle; a request presented during reset is not accepted.

Configuration
REQ-035 SHALL compile in the performance counters only when SALU_ISSUE_PERF_EN is defined.
REQ-036 SHALL, with SALU_ISSUE_PERF_EN defined, increment perf_issued_o on each issue and perf_taken_o on each pop with wb_br_taken_o=1, both wrapping modulo 2^32.
REQ-037 SHALL, without SALU_ISSUE_PERF_EN, tie perf_issued_o and perf_taken_o to 0 and keep the port list unchanged.

Verification
REQ-038 SHALL cover this scenario: ADD rs1=5 rs2=7 rd=3, wb_ready_i=1 -> wb_valid_o rises 2 cycles after issue, wb_data_o=12, wb_rd_o=3, wb_we_o=1, wb_ovf_o=0.
REQ-039 SHALL cover this scenario: ADD 0x7FFFFFFF+1 rd=0 -> wb_data_o=0x80000000, wb_ovf_o=1, wb_we_o=0.
REQ-040 SHALL cover this scenario: BEQ 9,9; BNE 9,9; BLT 0xFFFFFFFF,1; BGEU 0xFFFFFFFF,1 -> wb_br_taken_o = 1,0,1,1, each with wb_is_br_o=1 and wb_we_o=0.
REQ-041 SHALL cover this scenario: wb_ready_i=0 while issuing 3 back-to-back requests -> 2 accepted, req_ready_o=0 on the 3rd; release wb_ready_i -> results pop in order with no loss.
REQ-042 SHALL cover this scenario: 4 issues back-to-back, then flush_i pulsed 1 cycle after the 4th issue -> only the results that popped before the flush appear, wb_valid_o=0 afterwards, and the late ALU result is ignored.
REQ-043 SHALL cover this scenario: with SALU_ISSUE_PERF_EN, 10 issues including 3 taken branches -> perf_issued_o=10, perf_taken_o=3; without the macro both read 0.
